branch_resolve_ctrl: RTL

//   ID-stage branch sequencer for the pipelined MIPS32 core. Controls the branch comparator.
//   Per branch it: detects RAW hazards on the compare operand, stalls IF/ID, and picks the

---
 rtl/branch_resolve_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_ctrl
//  Brief    : ID-stage branch sequencer. It detects RAW hazards on the compare
//             operand, stalls IF/ID, selects the operand-A forwarding source,
//             drives the comparator, issues a registered PC redirect plus an
//             IF flush, and keeps saturating branch/taken counters.
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolve_ctrl #(
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [1:0]        id_branch_type,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [ADDR_W-1:0] id_npc,
   input  logic [ADDR_W-1:0] id_imm,
   input  logic              ex_wr_en,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_is_load,
   input  logic              mem_wr_en,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_is_load,
   input  logic              wb_wr_en,
   input  logic [REG_W-1:0]  wb_rd,
   output logic [1:0]        cmp_type,
   output logic [1:0]        opnd_sel,
   input  logic              cmp_taken,
   output logic              stall,
   output logic              pc_redirect,
   output logic              flush_if,
   output logic [ADDR_W-1:0] redirect_target,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  taken_count
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                cnt_q, cnt_d;          // remaining extra stall cycles (max 1)
   logic                pc_redirect_q, pc_redirect_d;
   logic [ADDR_W-1:0]   redirect_target_q, redirect_target_d;
   logic [CNT_W-1:0]    branch_count_q, branch_count_d;
   logic [CNT_W-1:0]    taken_count_q, taken_count_d;

   logic                w_rs_nz;
   logic                w_is_br;
   logic [1:0]          w_need;
   logic                w_resolve;

   // Branch qualification, stall-need decode and operand-A forwarding select
   always_comb begin
      w_rs_nz  = (id_rs != '0);
      // The instruction in ID during a redirect pulse is on the wrong path.
      w_is_br  = id_valid && (id_branch_type == 2'b01 || id_branch_type == 2'b10)
                 && !pc_redirect_q;
      w_need   = 2'd0;
      opnd_sel = 2'b00;
      if (w_rs_nz) begin
         if (ex_wr_en && ex_rd == id_rs && ex_is_load)
            w_need = 2'd2;
         else if (ex_wr_en && ex_rd == id_rs)
            w_need = 2'd1;
         else if (mem_wr_en && mem_rd == id_rs && mem_is_load)
            w_need = 2'd1;

         if (mem_wr_en && mem_rd == id_rs && !mem_is_load)
            opnd_sel = 2'b01;
         else if (wb_wr_en && wb_rd == id_rs)
            opnd_sel = 2'b10;
      end
   end

   // Next-state logic and stall/resolve decisions for the IDLE/WAIT sequencer
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall     = 1'b0;
      w_resolve = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_is_br) begin
               if (w_need == 2'd0) begin
                  w_resolve = 1'b1;
               end else begin
                  stall   = 1'b1;
                  cnt_d   = w_need[1];        // need-1 for need in {1,2}
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Hazard is not re-checked; the counted stall is sufficient.
            if (!id_valid) begin
               state_d = IDLE;
            end else if (cnt_q) begin
               stall = 1'b1;
               cnt_d = 1'b0;
            end else begin
               w_resolve = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      cmp_type = w_resolve ? id_branch_type : 2'b00;
   end

   // Redirect, target and saturating counter updates for a resolving branch
   always_comb begin
      pc_redirect_d     = w_resolve && cmp_taken;
      redirect_target_d = redirect_target_q;
      branch_count_d    = branch_count_q;
      taken_count_d     = taken_count_q;
      if (w_resolve) begin
         redirect_target_d = id_npc + id_imm;
         if (branch_count_q != c_cnt_max)
            branch_count_d = branch_count_q + 1'b1;
         if (cmp_taken && taken_count_q != c_cnt_max)
            taken_count_d = taken_count_q + 1'b1;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         cnt_q             <= 1'b0;
         pc_redirect_q     <= 1'b0;
         redirect_target_q <= '0;
         branch_count_q    <= '0;
         taken_count_q     <= '0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         pc_redirect_q     <= pc_redirect_d;
         redirect_target_q <= redirect_target_d;
         branch_count_q    <= branch_count_d;
         taken_count_q     <= taken_count_d;
      end
   end

   assign pc_redirect     = pc_redirect_q;
   assign flush_if        = pc_redirect_q;
   assign redirect_target = redirect_target_q;
   assign branch_count    = branch_count_q;
   assign taken_count     = taken_count_q;

endmodule
`default_nettype wire
